// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and constants for mem_req_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [11:0] MEM_XFER_BYTES = 12'd4;
  localparam int          RESP_BIT       = 0;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - combinational round-robin picker: first requester at or after ptr, wrapping
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

  logic found;

  // Two ascending passes: ports from ptr upward, then the wrapped ports below ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found && req[p] && (p >= int'(ptr))) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = IDX_W'(p);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!found && req[p] && (p < int'(ptr))) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter of cache ports onto one memory port; MEM_ARB_TIMEOUT_EN adds a WAIT timeout
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS-1:0]    req_we,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    req_ready,
  output logic [NUM_PORTS-1:0]    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic [31:0]             m_addr,
  output logic [31:0]             m_wdata,
  output logic                    m_awvalid,
  output logic                    m_arvalid,
  output logic                    m_wvalid,
  output logic [11:0]             m_wsize,
  output logic [11:0]             m_rsize,
  input  logic [31:0]             m_rdata,
  input  logic                    m_rvalid,
  input  logic [1:0]              m_w_resp,
  input  logic [1:0]              m_r_resp
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_t               state, next_state;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     port;
  logic                 we_q;
  logic [31:0]          rdata_q;
  logic                 done;
  logic                 timeout;
  logic [31:0]          addr_arr  [NUM_PORTS];
  logic [31:0]          wdata_arr [NUM_PORTS];
  logic                 unused_bits;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*32 +: 32];
    assign wdata_arr[g] = req_wdata[g*32 +: 32];
  end

  mem_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Completion bits only count while waiting on the matching transfer type.
  assign done = (state == WAIT) &&
                (we_q ? m_w_resp[RESP_BIT] : m_r_resp[RESP_BIT]);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) && !done &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn)                                    resp_err <= 1'b0;
    else if (state == WAIT && next_state == RESP) resp_err <= timeout;
  end
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req_valid) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (done || timeout) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rstn && state == IDLE) req_ready = grant;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr        <= '0;
      port       <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_awvalid  <= 1'b0;
      m_arvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      m_awvalid  <= 1'b0;
      m_arvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      resp_valid <= '0;
      if (state == IDLE && next_state == ISSUE) begin
        port      <= grant_idx;
        we_q      <= req_we[grant_idx];
        rdata_q   <= '0;
        m_addr    <= addr_arr[grant_idx];
        m_wdata   <= wdata_arr[grant_idx];
        m_awvalid <= req_we[grant_idx];
        m_wvalid  <= req_we[grant_idx];
        m_arvalid <= !req_we[grant_idx];
      end
      if (state == WAIT) begin
        if (m_rvalid) rdata_q <= m_rdata;
        if (next_state == RESP) begin
          resp_valid <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << port;
          if (timeout || we_q) resp_rdata <= '0;
          else if (m_rvalid)   resp_rdata <= m_rdata;
          else                 resp_rdata <= rdata_q;
        end
      end
      if (state == RESP) begin
        ptr <= (port == IDX_W'(NUM_PORTS - 1)) ? '0 : port + 1'b1;
      end
    end
  end

  assign m_wsize = MEM_XFER_BYTES;
  assign m_rsize = MEM_XFER_BYTES;

  assign unused_bits = ^{m_w_resp[1], m_r_resp[1], (TIMEOUT_CYCLES > 0)};

endmodule
